// File: rtl/ov7670_pattern_tx.sv
// OV7670 sensor bus emulator: drives pclk/vsync/href/d with RGB444 frames carrying
// a selectable test pattern, so the capture path can run without a real sensor.
module ov7670_pattern_tx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned PCLK_DIV    = 4
) (
    input  logic        GCLK,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    localparam int unsigned DIV_W = $clog2(PCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PCLK_DIV / 2);
    localparam logic [15:0] LINE_LAST = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] ACT_BYTES = 16'(2 * H_ACTIVE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             tick;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [15:0] h_cnt;
    logic [15:0] h_next;
    logic [15:0] line_cnt;
    logic [15:0] line_next;
    logic [15:0] lines_last;
    logic [1:0]  sel_lat;
    logic [1:0]  sel_next;
    logic [11:0] rgb_lat;
    logic [11:0] rgb_next;
    logic        leave_active;

    logic [9:0]  px;
    logic [8:0]  py;
    logic [11:0] pix;
    logic        vsync_next;
    logic        href_next;
    logic [7:0]  d_next;

    // Pixel-clock divider; the tick is the GCLK edge where div_cnt wraps (pclk falling edge)
    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        div_next = tick ? '0 : div_cnt + 1'b1;
    end

    // Line count of the current vertical region, minus one
    always_comb begin
        case (state)
            S_VSYNC:  lines_last = 16'(VSYNC_LINES - 1);
            S_VBACK:  lines_last = 16'(V_BACK - 1);
            S_ACTIVE: lines_last = 16'(V_ACTIVE - 1);
            default:  lines_last = 16'(V_FRONT - 1);
        endcase
    end

    // Next raster position and frame sequencing, applied only on a tick
    always_comb begin
        state_next   = state;
        h_next       = h_cnt;
        line_next    = line_cnt;
        sel_next     = sel_lat;
        rgb_next     = rgb_lat;
        leave_active = 1'b0;
        if (state == S_IDLE) begin
            if (enable) begin
                state_next = S_VSYNC;
                h_next     = '0;
                line_next  = '0;
                sel_next   = pattern_sel;
                rgb_next   = solid_rgb;
            end
        end else if (h_cnt != LINE_LAST) begin
            h_next = h_cnt + 16'd1;
        end else begin
            h_next = '0;
            if (line_cnt != lines_last) begin
                line_next = line_cnt + 16'd1;
            end else begin
                line_next = '0;
                case (state)
                    S_VSYNC:  state_next = S_VBACK;
                    S_VBACK:  state_next = S_ACTIVE;
                    S_ACTIVE: begin
                        state_next   = S_VFRONT;
                        leave_active = 1'b1;
                    end
                    default: begin
                        // Enable is only honoured here, so frames are never truncated
                        if (enable) begin
                            state_next = S_VSYNC;
                            sel_next   = pattern_sel;
                            rgb_next   = solid_rgb;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Pattern colour for the position being entered on this tick
    always_comb begin
        pix = '0;
        px  = h_next[10:1];
        py  = line_next[8:0];
        case (sel_lat)
            2'd0: pix = rgb_lat;
            2'd1: pix = {px[9:6], py[8:5], frame_count[3:0]};
            2'd2: begin
                case (px[9:7])
                    3'd0: pix = 12'hFFF;
                    3'd1: pix = 12'hFF0;
                    3'd2: pix = 12'h0FF;
                    3'd3: pix = 12'h0F0;
                    3'd4: pix = 12'hF0F;
                    3'd5: pix = 12'hF00;
                    3'd6: pix = 12'h00F;
                    default: pix = 12'h000;
                endcase
            end
            default: pix = (px[5] ^ py[5] ^ frame_count[0]) ? 12'hFFF : 12'h000;
        endcase
    end

    // Bus values for the next pclk cycle: R byte first, then {G,B}
    always_comb begin
        vsync_next = (state_next == S_VSYNC);
        href_next  = (state_next == S_ACTIVE) && (h_next < ACT_BYTES);
        d_next     = 8'h00;
        if (href_next) begin
            d_next = h_next[0] ? pix[7:0] : {4'h0, pix[11:8]};
        end
    end

    // Divider and pclk run continuously, including in IDLE
    always_ff @(posedge GCLK) begin
        if (reset) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pclk    <= (div_next >= DIV_HALF);
        end
    end

    // Raster state advances once per pclk period
    always_ff @(posedge GCLK) begin
        if (reset) begin
            state    <= S_IDLE;
            h_cnt    <= '0;
            line_cnt <= '0;
            sel_lat  <= '0;
            rgb_lat  <= '0;
        end else if (tick) begin
            state    <= state_next;
            h_cnt    <= h_next;
            line_cnt <= line_next;
            sel_lat  <= sel_next;
            rgb_lat  <= rgb_next;
        end
    end

    // Registered bus outputs plus end-of-frame pulse and counter
    always_ff @(posedge GCLK) begin
        if (reset) begin
            vsync       <= 1'b0;
            href        <= 1'b0;
            d           <= 8'h00;
            frame_done  <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            frame_done <= tick & leave_active;
            if (tick) begin
                vsync <= vsync_next;
                href  <= href_next;
                d     <= d_next;
                if (leave_active) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_pattern_tx.sv
// Bench for ov7670_pattern_tx: three instances (short-frame main, default geometry,
// tiny corner geometry) checked against a pixel scoreboard and timing models.
`timescale 1ns/1ps
module tb_ov7670_pattern_tx;

    localparam int MDIV = 2, MH_ACT = 640, MH_BLANK = 6, MVS = 1, MVB = 1, MV_ACT = 2, MVF = 1;
    localparam int M_LINE = 2 * MH_ACT + MH_BLANK;
    localparam int D_LINE = 1424;

    logic GCLK = 1'b0;
    always #5 GCLK = ~GCLK;

    // Main instance: full-width lines, few lines per frame
    logic m_reset = 1'b1, m_enable = 1'b0;
    logic [1:0] m_sel = 2'd0;
    logic [11:0] m_rgb = 12'h000;
    logic m_pclk, m_vsync, m_href, m_frame_done;
    logic [7:0] m_d, m_frame_count;

    // Default-parameter instance
    logic d_reset = 1'b1, d_enable = 1'b0;
    logic [1:0] d_sel = 2'd0;
    logic [11:0] d_rgb = 12'h123;
    logic d_pclk, d_vsync, d_href, d_frame_done;
    logic [7:0] d_d, d_frame_count;

    // Tiny-geometry instance, continuously enabled
    logic s_reset = 1'b1, s_enable = 1'b0;
    logic [1:0] s_sel = 2'd0;
    logic [11:0] s_rgb = 12'h3C7;
    logic s_pclk, s_vsync, s_href, s_frame_done;
    logic [7:0] s_d, s_frame_count;

    ov7670_pattern_tx #(
        .H_ACTIVE(MH_ACT), .V_ACTIVE(MV_ACT), .H_BLANK(MH_BLANK), .VSYNC_LINES(MVS),
        .V_BACK(MVB), .V_FRONT(MVF), .PCLK_DIV(MDIV)
    ) u_main (
        .GCLK(GCLK), .reset(m_reset), .enable(m_enable), .pattern_sel(m_sel),
        .solid_rgb(m_rgb), .pclk(m_pclk), .vsync(m_vsync), .href(m_href), .d(m_d),
        .frame_done(m_frame_done), .frame_count(m_frame_count)
    );

    ov7670_pattern_tx u_dflt (
        .GCLK(GCLK), .reset(d_reset), .enable(d_enable), .pattern_sel(d_sel),
        .solid_rgb(d_rgb), .pclk(d_pclk), .vsync(d_vsync), .href(d_href), .d(d_d),
        .frame_done(d_frame_done), .frame_count(d_frame_count)
    );

    ov7670_pattern_tx #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .VSYNC_LINES(1),
        .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)
    ) u_small (
        .GCLK(GCLK), .reset(s_reset), .enable(s_enable), .pattern_sel(s_sel),
        .solid_rgb(s_rgb), .pclk(s_pclk), .vsync(s_vsync), .href(s_href), .d(s_d),
        .frame_done(s_frame_done), .frame_count(s_frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];   // expected active bytes, in bus order
    int         vs_q[$];    // one token per frame expected to start
    int         fd_q[$];    // expected frame_count at each frame_done
    int         model_fc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference colour straight from the pattern rules, using plain arithmetic
    function automatic logic [11:0] ref_pixel(input int sel, input logic [11:0] rgb,
                                              input int x, input int y, input int fc);
        logic [11:0] c;
        case (sel)
            0: c = rgb;
            1: c = {4'((x / 64) % 16), 4'((y / 32) % 16), 4'(fc % 16)};
            2: begin
                case ((x / 128) % 8)
                    0: c = 12'hFFF;
                    1: c = 12'hFF0;
                    2: c = 12'h0FF;
                    3: c = 12'h0F0;
                    4: c = 12'hF0F;
                    5: c = 12'hF00;
                    6: c = 12'h00F;
                    default: c = 12'h000;
                endcase
            end
            default: c = ((((x / 32) + (y / 32) + fc) % 2) == 1) ? 12'hFFF : 12'h000;
        endcase
        return c;
    endfunction

    // Present a frame request and push everything it should produce
    task automatic issue_frame(input int sel, input logic [11:0] rgb);
        logic [11:0] p;
        m_sel    = 2'(sel);
        m_rgb    = rgb;
        m_enable = 1'b1;
        vs_q.push_back(1);
        for (int y = 0; y < MV_ACT; y++) begin
            for (int x = 0; x < MH_ACT; x++) begin
                p = ref_pixel(sel, rgb, x, y, model_fc);
                exp_q.push_back({4'h0, p[11:8]});
                exp_q.push_back(p[7:0]);
            end
        end
        model_fc = (model_fc + 1) % 256;
        fd_q.push_back(model_fc);
    endtask

    // Bounded wait on the main instance: 0 vsync, 1 href, 2 frame_done
    task automatic wait_main(input int which, input int max_cyc, input string name);
        int n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < max_cyc) begin
            @(posedge GCLK);
            #1;
            n++;
            case (which)
                0: hit = m_vsync;
                1: hit = m_href;
                default: hit = m_frame_done;
            endcase
        end
        if (!hit) check(name, hit, 1);
    endtask

    task automatic settle_empty(input string tag);
        repeat (2) @(posedge GCLK);
        #1;
        check({"bytes_left_", tag}, exp_q.size(), 0);
        check({"frames_left_", tag}, vs_q.size(), 0);
        check({"done_left_", tag}, fd_q.size(), 0);
    endtask

    task automatic idle_gap(input string tag);
        repeat ((MVF + 1) * M_LINE * MDIV + 20) @(posedge GCLK);
        #1;
        check({"idle_vsync_", tag}, m_vsync, 0);
        check({"idle_href_", tag}, m_href, 0);
    endtask

    // Pixel/geometry monitor for the main instance, one sample per pclk rise
    initial begin : mon_main
        logic pclk_prev, vs_prev, hr_prev;
        int vs_run, hi_run, lo_run, lines;
        pclk_prev = 0; vs_prev = 0; hr_prev = 0;
        vs_run = 0; hi_run = 0; lo_run = 0; lines = 0;
        forever begin
            @(negedge GCLK);
            if (m_reset) begin
                pclk_prev = 0; vs_prev = 0; hr_prev = 0;
                vs_run = 0; hi_run = 0; lo_run = 0; lines = 0;
            end else begin
                if (m_pclk && !pclk_prev) begin
                    if (m_vsync && !vs_prev) begin
                        if (vs_q.size() == 0) check("unexpected_vsync", m_vsync, 0);
                        else void'(vs_q.pop_front());
                        vs_run = 0;
                        lines  = 0;
                    end
                    if (!m_vsync && vs_prev) check("vsync_width", vs_run, MVS * M_LINE);
                    if (m_vsync) vs_run++;
                    if (m_href) begin
                        if (!hr_prev) begin
                            if (lines > 0) check("hblank_width", lo_run, MH_BLANK);
                            hi_run = 0;
                        end
                        hi_run++;
                        if (exp_q.size() == 0) check("unexpected_byte", m_href, 0);
                        else check("pixel_byte", m_d, exp_q.pop_front());
                    end else begin
                        if (hr_prev) begin
                            check("href_width", hi_run, 2 * MH_ACT);
                            lines++;
                            lo_run = 0;
                        end
                        lo_run++;
                        check("d_zero_outside_href", m_d, 0);
                    end
                    vs_prev = m_vsync;
                    hr_prev = m_href;
                end
                pclk_prev = m_pclk;
            end
        end
    end

    // frame_done monitor: single-cycle pulse carrying the expected count
    initial begin : mon_done
        logic fd_prev;
        fd_prev = 0;
        forever begin
            @(negedge GCLK);
            if (m_reset) begin
                fd_prev = 0;
            end else begin
                if (m_frame_done) begin
                    check("frame_done_width", fd_prev, 0);
                    if (fd_q.size() == 0) check("unexpected_frame_done", m_frame_done, 0);
                    else check("frame_count", m_frame_count, fd_q.pop_front());
                end
                fd_prev = m_frame_done;
            end
        end
    end

    task automatic main_seq();
        repeat (3) @(posedge GCLK);
        #1;
        check("m_reset_bus", {m_pclk, m_vsync, m_href, m_d, m_frame_done}, 0);
        check("m_reset_count", m_frame_count, 0);
        m_reset = 1'b0;

        // Solid A5C; pattern inputs scrambled and enable dropped mid-frame
        issue_frame(0, 12'hA5C);
        wait_main(0, 20000, "wait_vsync_a");
        m_sel = 2'($urandom); m_rgb = 12'($urandom); m_enable = 1'b0;
        wait_main(2, 20000, "wait_done_a");
        settle_empty("a");
        idle_gap("a");

        // Colour bars; switch to checkerboard and drop enable during an active line
        issue_frame(2, 12'($urandom));
        wait_main(1, 20000, "wait_href_b");
        m_sel = 2'd3; m_enable = 1'b0;
        wait_main(2, 20000, "wait_done_b");
        settle_empty("b");
        idle_gap("b");

        // Checkerboard, then a back-to-back gradient frame
        issue_frame(3, 12'($urandom));
        wait_main(2, 20000, "wait_done_c");
        settle_empty("c");
        issue_frame(1, 12'($urandom));
        wait_main(0, 4000, "wait_vsync_d");
        m_sel = 2'($urandom); m_rgb = 12'($urandom);
        wait_main(1, 20000, "wait_href_d");
        repeat ($urandom_range(1, 2000)) @(posedge GCLK);
        #1;

        // Reset in the middle of an active line
        m_reset = 1'b1;
        exp_q.delete(); vs_q.delete(); fd_q.delete();
        model_fc = 0;
        @(posedge GCLK);
        #1;
        check("midline_reset_href", m_href, 0);
        check("midline_reset_vsync", m_vsync, 0);
        check("midline_reset_d", m_d, 0);
        check("midline_reset_count", m_frame_count, 0);
        check("midline_reset_pclk", m_pclk, 0);
        m_reset = 1'b0;

        // Restart: full vsync period and count from zero
        issue_frame($urandom_range(0, 3), 12'($urandom));
        wait_main(0, 20000, "wait_vsync_e");
        m_sel = 2'($urandom); m_rgb = 12'($urandom); m_enable = 1'b0;
        wait_main(2, 20000, "wait_done_e");
        settle_empty("e");
    endtask

    task automatic default_seq();
        int n, width;
        logic href_seen;
        repeat (2) @(posedge GCLK);
        #1;
        check("d_reset_bus", {d_pclk, d_vsync, d_href, d_d, d_frame_done}, 0);
        d_reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge GCLK);
            #1;
            check("d_pclk_wave", d_pclk, ((k % 4) >= 2) ? 1 : 0);
            check("d_idle_bus", {d_vsync, d_href, d_d, d_frame_done}, 0);
        end
        check("d_idle_count", d_frame_count, 0);
        d_enable = 1'b1;
        n = 0;
        while (!d_vsync && n < 16) begin
            @(posedge GCLK);
            #1;
            n++;
        end
        check("d_vsync_start", d_vsync, 1);
        width = 0;
        href_seen = 1'b0;
        while (d_vsync && width < 20000) begin
            width++;
            if (d_href) href_seen = 1'b1;
            @(posedge GCLK);
            #1;
        end
        check("d_vsync_width", width, 3 * D_LINE * 4);
        check("d_href_in_vsync", href_seen, 0);
        d_enable = 1'b0;
        d_reset  = 1'b1;
    endtask

    task automatic small_seq();
        int cyc, last_rise, frames;
        logic prev_vs;
        @(posedge GCLK);
        #1;
        s_reset  = 1'b0;
        s_enable = 1'b1;
        cyc = 0; last_rise = -1; frames = 0; prev_vs = 1'b0;
        while (frames < 258 && cyc < 40000) begin
            @(posedge GCLK);
            #1;
            cyc++;
            if (s_vsync && !prev_vs) begin
                // 5 lines x 10 ticks x 2 GCLK, no idle gap between frames
                if (last_rise >= 0) check("s_frame_period", cyc - last_rise, 100);
                last_rise = cyc;
            end
            prev_vs = s_vsync;
            if (s_frame_done) begin
                frames++;
                check("s_frame_count", s_frame_count, frames % 256);
            end
        end
        if (frames < 258) check("s_frames_seen", frames, 258);
        s_enable = 1'b0;
    endtask

    initial begin
        repeat (150000) @(posedge GCLK);
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            main_seq();
            default_seq();
            small_seq();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
